// File: rtl/host_ft245_write_model_fifo.sv
// Host-side FT245 transmit bus-functional model: paces the DUT with TXE#, captures
// each WR# falling edge into a show-ahead receive FIFO, and keeps status counters.
module host_ft245_write_model_fifo #(
    parameter int DATA_W          = 8,
    parameter int DEPTH           = 16,
    parameter int ADDR_W          = 4,
    parameter int TXE_BUSY_CYCLES = 8,
    parameter int CNT_W           = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ENABLE,
    output logic              HOST_FT245_TXE_N,
    input  logic              HOST_FT245_WR,
    input  logic [DATA_W-1:0] HOST_FT245_WRITE_BYTE,
    output logic [DATA_W-1:0] RX_DATA,
    output logic              RX_VALID,
    input  logic              RX_READY,
    output logic [ADDR_W:0]   RX_COUNT,
    output logic [CNT_W-1:0]  BYTE_COUNT,
    output logic              PROTO_ERR,
    input  logic              CLR_STATUS
);

    localparam int BUSY_W = (TXE_BUSY_CYCLES > 1) ? $clog2(TXE_BUSY_CYCLES) : 1;
    localparam logic [BUSY_W-1:0] BUSY_LOAD = BUSY_W'(TXE_BUSY_CYCLES - 1);
    localparam logic [BUSY_W-1:0] BUSY_ZERO = '0;
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   COUNT_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE,
        READY,
        BUSY,
        WAIT_WR_HIGH
    } state_t;

    state_t              state_reg;
    logic                txe_n_reg;
    logic [BUSY_W-1:0]   busy_cnt_reg;
    logic                wr_q_reg;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   wptr_reg;
    logic [ADDR_W-1:0]   rptr_reg;
    logic [ADDR_W-1:0]   rptr_plus1;
    logic [ADDR_W:0]     count_reg;
    logic [DATA_W-1:0]   rx_data_reg;

    logic [CNT_W-1:0]    byte_count_reg;
    logic                proto_err_reg;

    logic                wr_fall;
    logic                push;
    logic                pop;
    logic                proto_evt;

    assign wr_fall    = wr_q_reg & ~HOST_FT245_WR;
    assign push       = wr_fall & (state_reg == READY);
    assign proto_evt  = wr_fall & (state_reg != READY);
    assign pop        = RX_READY & (count_reg != COUNT_ZERO);
    assign rptr_plus1 = rptr_reg + ADDR_W'(1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_q_reg <= 1'b1;
        end else begin
            wr_q_reg <= HOST_FT245_WR;
        end
    end

    // TXE# is registered alongside the state so it is low exactly while in READY.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= IDLE;
            txe_n_reg    <= 1'b1;
            busy_cnt_reg <= BUSY_ZERO;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (ENABLE && (count_reg < DEPTH_C) && HOST_FT245_WR) begin
                        state_reg <= READY;
                        txe_n_reg <= 1'b0;
                    end
                end
                READY: begin
                    if (push) begin
                        state_reg    <= BUSY;
                        txe_n_reg    <= 1'b1;
                        busy_cnt_reg <= BUSY_LOAD;
                    end else if (!ENABLE) begin
                        state_reg <= IDLE;
                        txe_n_reg <= 1'b1;
                    end
                end
                BUSY: begin
                    if (busy_cnt_reg == BUSY_ZERO) begin
                        state_reg <= WAIT_WR_HIGH;
                    end else begin
                        busy_cnt_reg <= busy_cnt_reg - BUSY_W'(1);
                    end
                end
                WAIT_WR_HIGH: begin
                    if (HOST_FT245_WR) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    txe_n_reg <= 1'b1;
                end
            endcase
        end
    end

    // Storage array without reset so it maps onto RAM.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wptr_reg] <= HOST_FT245_WRITE_BYTE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                wptr_reg <= wptr_reg + ADDR_W'(1);
            end
            if (pop) begin
                rptr_reg <= rptr_plus1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + COUNT_ONE;
                2'b01:   count_reg <= count_reg - COUNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Show-ahead head register: the incoming byte bypasses the array whenever it
    // becomes the new head (empty FIFO, or last entry popped on the same cycle).
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_data_reg <= '0;
        end else if (pop && (count_reg > COUNT_ONE)) begin
            rx_data_reg <= mem[rptr_plus1];
        end else if (push && ((count_reg == COUNT_ZERO) || pop)) begin
            rx_data_reg <= HOST_FT245_WRITE_BYTE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || CLR_STATUS) begin
            byte_count_reg <= '0;
            proto_err_reg  <= 1'b0;
        end else begin
            if (push) begin
                byte_count_reg <= byte_count_reg + CNT_W'(1);
            end
            if (proto_evt) begin
                proto_err_reg <= 1'b1;
            end
        end
    end

    assign HOST_FT245_TXE_N = txe_n_reg;
    assign RX_DATA          = rx_data_reg;
    assign RX_VALID         = (count_reg != COUNT_ZERO);
    assign RX_COUNT         = count_reg;
    assign BYTE_COUNT       = byte_count_reg;
    assign PROTO_ERR        = proto_err_reg;

endmodule

// File: tb/tb_host_ft245_write_model_fifo.sv
// Directed bench for host_ft245_write_model_fifo: a queue-based reference model is
// compared with the outputs every cycle, plus literal expectations per scenario.
module tb_host_ft245_write_model_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int BUSY   = 8;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              wr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              clr;

    logic              txe_n;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic [ADDR_W:0]   rx_count;
    logic [CNT_W-1:0]  byte_count;
    logic              proto_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    host_ft245_write_model_fifo #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .TXE_BUSY_CYCLES(BUSY), .CNT_W(CNT_W)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .ENABLE(en),
        .HOST_FT245_TXE_N(txe_n),
        .HOST_FT245_WR(wr),
        .HOST_FT245_WRITE_BYTE(wdata),
        .RX_DATA(rx_data),
        .RX_VALID(rx_valid),
        .RX_READY(ready),
        .RX_COUNT(rx_count),
        .BYTE_COUNT(byte_count),
        .PROTO_ERR(proto_err),
        .CLR_STATUS(clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Reference model: TXE# low means the host can take a byte; after a byte the
    // host is busy for BUSY cycles, then waits for WR# high, then idles one cycle.
    logic [DATA_W-1:0] mq[$];
    logic [CNT_W-1:0]  m_bc;
    bit                m_err;
    bit                m_txe;
    bit                m_wait;
    int                m_busy;
    bit                m_prev_wr;
    bit                chk_en = 1'b0;
    int                m_sz;
    bit                m_fall;
    bit                m_acc;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_bc      = '0;
            m_err     = 1'b0;
            m_txe     = 1'b1;
            m_wait    = 1'b0;
            m_busy    = 0;
            m_prev_wr = 1'b1;
        end else begin
            m_sz   = mq.size();
            m_fall = m_prev_wr && !wr;
            m_acc  = m_fall && !m_txe;
            if (ready && m_sz > 0) void'(mq.pop_front());
            if (m_acc) mq.push_back(wdata);
            if (clr) begin
                m_bc  = '0;
                m_err = 1'b0;
            end else begin
                if (m_acc) m_bc = m_bc + 1'b1;
                if (m_fall && !m_acc) m_err = 1'b1;
            end
            if (m_acc) begin
                m_txe  = 1'b1;
                m_busy = BUSY;
            end else if (!m_txe) begin
                if (!en) m_txe = 1'b1;
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) m_wait = 1'b1;
            end else if (m_wait) begin
                if (wr) m_wait = 1'b0;
            end else if (en && m_sz < DEPTH && wr) begin
                m_txe = 1'b0;
            end
            m_prev_wr = wr;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("txe_n", 32'(txe_n), 32'(m_txe));
            check("rx_valid", 32'(rx_valid), 32'(mq.size() > 0));
            check("rx_count", 32'(rx_count), 32'(mq.size()));
            check("byte_count", 32'(byte_count), 32'(m_bc));
            check("proto_err", 32'(proto_err), 32'(m_err));
            if (mq.size() > 0) check("rx_data", 32'(rx_data), 32'(mq[0]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_txe_low(input string name);
        int n = 0;
        while (txe_n !== 1'b0 && n < 100) begin
            step();
            n++;
        end
        check(name, 32'(txe_n), 32'd0);
    endtask

    task automatic do_write(input logic [DATA_W-1:0] d, input bit pop_same);
        wait_txe_low("wait_ready");
        wdata = d;
        wr    = 1'b0;
        ready = pop_same;
        step();
        wr    = 1'b1;
        ready = 1'b0;
        step();
        $display("write %02h pop=%0d count=%0d", d, pop_same, rx_count);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; en = 1'b0; wr = 1'b1; wdata = '0; ready = 1'b0; clr = 1'b0;
        repeat (3) step();
        chk_en = 1'b1;
        check("reset_txe", 32'(txe_n), 32'd1);
        check("reset_count", 32'(rx_count), 32'd0);
        check("reset_data", 32'(rx_data), 32'd0);

        // Single write of A5
        rst = 1'b0; en = 1'b1;
        step();
        check("txe_low_after_reset", 32'(txe_n), 32'd0);
        wdata = 8'hA5; wr = 1'b0;
        step();
        wr = 1'b1;
        n = 0;
        while (txe_n === 1'b1 && n < 50) begin
            n++;
            step();
        end
        // 8 busy cycles, then one WAIT_WR_HIGH and one IDLE cycle
        check("txe_high_cycles", 32'(n), 32'd10);
        check("a5_valid", 32'(rx_valid), 32'd1);
        check("a5_data", 32'(rx_data), 32'hA5);
        check("a5_bytes", 32'(byte_count), 32'd1);
        $display("single write: txe high %0d cycles", n);
        ready = 1'b1; step(); ready = 1'b0;

        // Fill to full, then backpressure release and in-order drain
        for (int i = 0; i < 16; i++) do_write(8'(i), 1'b0);
        repeat (15) step();
        check("full_txe", 32'(txe_n), 32'd1);
        check("full_count", 32'(rx_count), 32'd16);
        check("full_head", 32'(rx_data), 32'h00);
        ready = 1'b1; step(); ready = 1'b0;
        check("txe_after_pop_edge", 32'(txe_n), 32'd1);
        step();
        check("txe_low_after_pop", 32'(txe_n), 32'd0);
        ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            check("drain_order", 32'(rx_data), 32'(i));
            step();
        end
        ready = 1'b0;
        check("drain_empty", 32'(rx_valid), 32'd0);

        // Strobe during BUSY
        do_write(8'h55, 1'b0);
        wr = 1'b0; step(); wr = 1'b1; step();
        check("perr_set", 32'(proto_err), 32'd1);
        check("perr_count", 32'(rx_count), 32'd1);
        check("perr_bytes", 32'(byte_count), 32'd18);
        clr = 1'b1; step(); clr = 1'b0;
        check("perr_clr", 32'(proto_err), 32'd0);
        check("bytes_clr", 32'(byte_count), 32'd0);
        ready = 1'b1; step(); ready = 1'b0;

        // ENABLE dropped while READY
        wait_txe_low("en_ready");
        en = 1'b0; step();
        check("en_low_txe", 32'(txe_n), 32'd1);
        en = 1'b1;

        // WR# held low past busy time
        wait_txe_low("hold_ready");
        wdata = 8'h77; wr = 1'b0;
        step();
        repeat (20) step();
        check("hold_txe", 32'(txe_n), 32'd1);
        check("hold_bytes", 32'(byte_count), 32'd1);
        check("hold_count", 32'(rx_count), 32'd1);
        wr = 1'b1; step();
        wait_txe_low("hold_release");
        check("hold_bytes_after", 32'(byte_count), 32'd1);
        ready = 1'b1; step(); ready = 1'b0;

        // Push and pop together at count 3, across pointer wrap
        for (int i = 0; i < 20; i++) begin
            do_write(8'(8'h30 + i), i >= 3);
            if (i == 3) check("pushpop_count", 32'(rx_count), 32'd3);
        end
        check("wrap_count", 32'(rx_count), 32'd3);
        ready = 1'b1;
        for (int i = 17; i < 20; i++) begin
            check("wrap_order", 32'(rx_data), 32'(8'h30 + i));
            step();
        end
        ready = 1'b0;

        // CLR_STATUS coinciding with an accepted byte
        wait_txe_low("clr_ready");
        wdata = 8'h99; wr = 1'b0; clr = 1'b1;
        step();
        wr = 1'b1; clr = 1'b0;
        step();
        check("clr_wins_bytes", 32'(byte_count), 32'd0);
        check("clr_byte_stored", 32'(rx_count), 32'd1);
        ready = 1'b1; step(); ready = 1'b0;

        // Reset in BUSY with 5 entries
        for (int i = 0; i < 5; i++) do_write(8'(8'h60 + i), 1'b0);
        check("pre_rst_count", 32'(rx_count), 32'd5);
        rst = 1'b1; step();
        check("rst_count", 32'(rx_count), 32'd0);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_txe", 32'(txe_n), 32'd1);
        check("rst_bytes", 32'(byte_count), 32'd0);
        rst = 1'b0;
        wait_txe_low("post_rst_ready");
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
